// File: rtl/byte_pkg.sv
// byte_pkg: opcodes, instruction formats and the stage record shared by the byte unit.
package byte_pkg;

    localparam logic [0:10] OP_CNTB  = 11'b01010110100;
    localparam logic [0:10] OP_AVGB  = 11'b00011010011;
    localparam logic [0:10] OP_ABSDB = 11'b00001010011;
    localparam logic [0:10] OP_SUMB  = 11'b01001010011;
    localparam logic [0:10] OP_NOP   = 11'b00000000000;

    typedef enum logic [2:0] {
        FMT_RR, FMT_RRR, FMT_RI7, FMT_RI8, FMT_RI10, FMT_RI16, FMT_RI18
    } fmt_e;

    localparam int STAGE_DATA_W = 128;
    localparam int STAGE_ADDR_W = 7;

    typedef struct packed {
        logic [STAGE_DATA_W-1:0] rt;
        logic [STAGE_ADDR_W-1:0] rt_addr;
        logic                    reg_write;
    } stage_t;

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b0, b[i]};
        return n;
    endfunction

endpackage

// File: rtl/byte_unit_alu.sv
// byte_alu: combinational per-lane cntb/avgb/absdb/sumb compute; valid_op flags a recognised opcode.
module byte_alu
    import byte_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic [0:10]       op,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] rb,
    output logic [DATA_W-1:0] rt,
    output logic              valid_op
);

    localparam int NB = DATA_W / 8;
    localparam int NW = DATA_W / 32;

    logic [DATA_W-1:0] cnt_v, avg_v, absd_v, sum_v;

    always_comb begin
        cnt_v  = '0;
        avg_v  = '0;
        absd_v = '0;
        sum_v  = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_v[8*i+:8]  = {4'b0, popcount8(ra[8*i+:8])};
            avg_v[8*i+:8]  = 8'((9'(ra[8*i+:8]) + 9'(rb[8*i+:8]) + 9'd1) >> 1);
            absd_v[8*i+:8] = ra[8*i+:8] > rb[8*i+:8] ? ra[8*i+:8] - rb[8*i+:8] : rb[8*i+:8] - ra[8*i+:8];
        end
        // each word: low halfword sums ra bytes, high halfword sums rb bytes
        for (int w = 0; w < NW; w++)
            for (int j = 0; j < 4; j++) begin
                sum_v[32*w+:16]    = sum_v[32*w+:16] + 16'(ra[32*w+8*j+:8]);
                sum_v[32*w+16+:16] = sum_v[32*w+16+:16] + 16'(rb[32*w+8*j+:8]);
            end
    end

    always_comb begin
        valid_op = op == OP_CNTB || op == OP_AVGB || op == OP_ABSDB || op == OP_SUMB;
        rt = op == OP_NOP   ? '0 :
             op == OP_CNTB  ? cnt_v :
             op == OP_AVGB  ? avg_v :
             op == OP_ABSDB ? absd_v :
             op == OP_SUMB  ? sum_v : '0;
    end

endmodule

// File: rtl/byte_unit_pipe.sv
// byte_unit_pipe: LATENCY-deep byte-op execute pipe with flush; define BYTE_UNIT_FWD_EN
// to expose per-stage forwarding taps on fwd_taps (stage 0 at the LSBs).
module byte_unit_pipe
    import byte_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:10]       op,
    input  logic [2:0]        format,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] rb,
    input  logic              reg_write,
    input  logic              flush,
    output logic [DATA_W-1:0] rt_wb,
    output logic [ADDR_W-1:0] rt_addr_wb,
    output logic              reg_write_wb,
    output logic              busy
`ifdef BYTE_UNIT_FWD_EN
    ,
    output logic [LATENCY*(DATA_W+ADDR_W+1)-1:0] fwd_taps
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] rt;
        logic [ADDR_W-1:0] rt_addr;
        logic              reg_write;
    } stage_w_t;

    stage_w_t          stg [LATENCY];
    stage_w_t          nxt;
    logic [DATA_W-1:0] alu_rt;
    logic              valid_op;
    logic              sel;

    byte_alu #(.DATA_W(DATA_W)) u_alu (
        .op      (op),
        .ra      (ra),
        .rb      (rb),
        .rt      (alu_rt),
        .valid_op(valid_op)
    );

    // non-RR formats and unrecognised opcodes enter the pipe as all-zero bubbles
    always_comb begin
        sel           = format == 3'(FMT_RR) && valid_op;
        nxt.rt        = sel ? alu_rt : '0;
        nxt.rt_addr   = sel ? rt_addr : '0;
        nxt.reg_write = sel && reg_write && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
        end else begin
            stg[0] <= nxt;
            for (int i = 1; i < LATENCY; i++)
                stg[i] <= '{rt: stg[i-1].rt, rt_addr: stg[i-1].rt_addr, reg_write: stg[i-1].reg_write && !flush};
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) busy = busy | stg[i].reg_write;
    end

    assign rt_wb        = stg[LATENCY-1].rt;
    assign rt_addr_wb   = stg[LATENCY-1].rt_addr;
    assign reg_write_wb = stg[LATENCY-1].reg_write;

`ifdef BYTE_UNIT_FWD_EN
    for (genvar g = 0; g < LATENCY; g++) begin : g_tap
        assign fwd_taps[g*(DATA_W+ADDR_W+1)+:DATA_W+ADDR_W+1] = stg[g];
    end
`endif

endmodule
